// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round sequencer.
package sha256_pkg;

    localparam int ROUNDS    = 64;
    localparam int MSG_WORDS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREF,
        ST_RND,
        ST_FIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] CTRL_SCHED = 2'b00;
    localparam logic [1:0] CTRL_EXP   = 2'b01;
    localparam logic [1:0] CTRL_FIN   = 2'b10;
    localparam logic [1:0] CTRL_IDLE  = 2'b11;

    localparam logic [31:0] K15_STD = 32'hc19bf174;

endpackage

// File: rtl/sha256_round_cnt.sv
// Round counter: synchronous clear, enable, saturates at LAST and flags it on tc.
module sha256_round_cnt #(
    parameter int W    = 6,
    parameter int LAST = 63
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(LAST));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequences one SHA-256 compression per accepted block: K-ROM prefetch, rounds, digest add.
// Optional macro SHA256_OPT_K15_EN enables the first-block optimised K15 request (opt_en).
module sha256_round_ctrl #(
    parameter int ROUNDS    = 64,
    parameter int ADDR_W    = 6,
    parameter int MSG_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    input  logic              blk_first,
    input  logic              blk_last,
    output logic              blk_ready,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              iv_control,
    output logic [1:0]        control,
    output logic              opt_en,
    output logic              core_init,
    output logic              core_en,
    output logic              w_load,
    output logic              w_expand,
    output logic [ADDR_W-1:0] round,
    output logic              digest_add,
    output logic              digest_valid,
    output logic              busy
);
    import sha256_pkg::*;

    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(MSG_WORDS - 1);
    localparam logic [ADDR_W-1:0] OPT_ADDR  = ADDR_W'(15);

    state_t            state, state_nxt;
    logic              first_q, last_q;
    logic [ADDR_W-1:0] cnt;
    logic              cnt_tc;
    logic              in_rnd;

    assign in_rnd = (state == ST_RND);

    sha256_round_cnt #(
        .W    (ADDR_W),
        .LAST (ROUNDS - 1)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!in_rnd),
        .en  (in_rnd),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && blk_valid) begin
                first_q <= blk_first;
                last_q  <= blk_last;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        blk_ready    = 1'b0;
        rom_rd       = 1'b0;
        rom_addr     = '0;
        control      = CTRL_IDLE;
        core_init    = 1'b0;
        core_en      = 1'b0;
        w_load       = 1'b0;
        w_expand     = 1'b0;
        round        = '0;
        digest_add   = 1'b0;
        digest_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            ST_IDLE: begin
                blk_ready = 1'b1;
                busy      = 1'b0;
                if (blk_valid) begin
                    state_nxt = ST_PREF;
                end
            end
            ST_PREF: begin
                rom_rd    = 1'b1;
                core_init = 1'b1;
                control   = CTRL_SCHED;
                state_nxt = ST_RND;
            end
            ST_RND: begin
                core_en  = 1'b1;
                round    = cnt;
                w_load   = (cnt <= LOAD_LAST);
                w_expand = (cnt > LOAD_LAST);
                control  = (cnt <= LOAD_LAST) ? CTRL_SCHED : CTRL_EXP;
                // Fetch one round ahead so K is waiting on the registered ROM output.
                if (!cnt_tc) begin
                    rom_rd   = 1'b1;
                    rom_addr = cnt + 1'b1;
                end else begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                digest_add = 1'b1;
                control    = CTRL_FIN;
                state_nxt  = last_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                digest_valid = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign iv_control = first_q;

`ifdef SHA256_OPT_K15_EN
    assign opt_en = first_q && in_rnd && rom_rd && (rom_addr == OPT_ADDR);
`else
    assign opt_en = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl with a registered K-ROM model on its outputs.
module tb_sha256_round_ctrl;

    localparam logic [31:0] KTAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] K15_ALT = 32'h5a5a0f15;
`ifdef SHA256_OPT_K15_EN
    localparam bit OPT = 1'b1;
`else
    localparam bit OPT = 1'b0;
`endif

    typedef struct packed {
        logic       ready;
        logic       rd;
        logic [5:0] addr;
        logic       iv;
        logic [1:0] ctrl;
        logic       opt;
        logic       init;
        logic       en;
        logic       wl;
        logic       we;
        logic [5:0] rnd;
        logic       dadd;
        logic       dval;
        logic       busy;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       blk_valid, blk_first, blk_last;
    logic       blk_ready, rom_rd, iv_control, opt_en, core_init, core_en;
    logic       w_load, w_expand, digest_add, digest_valid, busy;
    logic [5:0] rom_addr, round;
    logic [1:0] control;
    logic [31:0] rom_q;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   acc_cyc      = 0;
    logic iv_model     = 1'b0;
    logic mon_en       = 1'b0;
    vec_t exp_q [$];

    sha256_round_ctrl #(.ROUNDS(64), .ADDR_W(6), .MSG_WORDS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (blk_valid),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
        .blk_ready    (blk_ready),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .iv_control   (iv_control),
        .control      (control),
        .opt_en       (opt_en),
        .core_init    (core_init),
        .core_en      (core_en),
        .w_load       (w_load),
        .w_expand     (w_expand),
        .round        (round),
        .digest_add   (digest_add),
        .digest_valid (digest_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered K-ROM driven by the DUT's address and strobe.
    initial rom_q = '0;
    always @(posedge clk) begin
        if (rom_rd) rom_q <= (opt_en && rom_addr == 6'd15) ? K15_ALT : KTAB[rom_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        tests_run++;
        if (obs !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, req, cyc);
        end
    endtask

    function automatic vec_t idle_vec(input logic iv);
        vec_t v = '0;
        v.ready = 1'b1;
        v.iv    = iv;
        v.ctrl  = 2'b11;
        return v;
    endfunction

    task automatic push_block(input logic f, input logic l);
        vec_t v;
        v = '0; v.rd = 1'b1; v.iv = f; v.ctrl = 2'b00; v.init = 1'b1; v.busy = 1'b1;
        exp_q.push_back(v);
        for (int r = 0; r < 64; r++) begin
            v = '0; v.iv = f; v.busy = 1'b1; v.en = 1'b1; v.rnd = 6'(r);
            v.rd   = (r <= 62);
            v.addr = (r <= 62) ? 6'(r + 1) : 6'd0;
            v.ctrl = (r <= 15) ? 2'b00 : 2'b01;
            v.wl   = (r < 16);
            v.we   = (r >= 16);
            v.opt  = OPT && f && (r == 14);
            exp_q.push_back(v);
        end
        v = '0; v.iv = f; v.busy = 1'b1; v.dadd = 1'b1; v.ctrl = 2'b10;
        exp_q.push_back(v);
        if (l) begin
            v = '0; v.iv = f; v.busy = 1'b1; v.dval = 1'b1; v.ctrl = 2'b11;
            exp_q.push_back(v);
        end
    endtask

    always @(negedge clk) begin
        vec_t        ev, ov;
        logic [31:0] k_exp;
        if (mon_en) begin
            cyc++;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : idle_vec(iv_model);
            ov.ready = blk_ready;  ov.rd   = rom_rd;    ov.addr = rom_addr;   ov.iv = iv_control;
            ov.ctrl  = control;    ov.opt  = opt_en;    ov.init = core_init;  ov.en = core_en;
            ov.wl    = w_load;     ov.we   = w_expand;  ov.rnd  = round;      ov.dadd = digest_add;
            ov.dval  = digest_valid; ov.busy = busy;
            chk("outputs", 64'(ov), 64'(ev));
            if (ev.en) begin
                k_exp = (OPT && ev.iv && ev.rnd == 6'd15) ? K15_ALT : KTAB[ev.rnd];
                chk("rom_k", 64'(rom_q), 64'(k_exp));
            end
            if (digest_add)   chk("lat_digest_add", 64'(cyc - acc_cyc), 64'd66);
            if (digest_valid) chk("lat_digest_valid", 64'(cyc - acc_cyc), 64'd67);
            if (rst) begin
                exp_q.delete();
                iv_model = 1'b0;
            end else if (ev.ready && blk_valid) begin
                push_block(blk_first, blk_last);
                iv_model = blk_first;
                acc_cyc  = cyc;
            end
        end
    end

    task automatic send_one(input logic f, input logic l);
        blk_valid = 1'b1; blk_first = f; blk_last = l;
        @(posedge clk); #1;
        blk_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
        @(posedge clk); #1 mon_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Single-block message.
        send_one(1'b1, 1'b1);
        repeat (75) @(posedge clk); #1;

        // Two-block message with blk_valid held through block 1; block 2 lands the cycle after FIN.
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
        @(posedge clk); #1;
        blk_first = 1'b0; blk_last = 1'b1;
        repeat (67) @(posedge clk); #1;
        blk_valid = 1'b0;
        repeat (75) @(posedge clk); #1;

        // Reset in round 30, then a clean restart with a non-first block.
        send_one(1'b1, 1'b1);
        repeat (31) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        send_one(1'b0, 1'b1);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk); #1;
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequences one SHA-256 compression per 512-bit block. Drives the registered K-constant ROM (RD/addr/iv_control/control/opt_en) and the round datapath (init, round enable, W load/expand, digest add).
- Accepts blocks through a valid/ready handshake and tracks first/last block of a message.
- Sits between the message-block buffer and the compression core. The digest datapath itself is outside this block.

Parameters:
- ROUNDS, 64, compression rounds per block; must be 64 for SHA-256.
- ADDR_W, 6, ROM address width; must satisfy 2**ADDR_W >= ROUNDS.
- MSG_WORDS, 16, rounds that take W directly from the block (w_load); remaining rounds use w_expand.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- blk_valid  in  1  a message block is available.
- blk_first  in  1  sampled on accept; block is the first of a message (core loads IV).
- blk_last  in  1  sampled on accept; block is the last of a message (digest_valid pulses).
- blk_ready  out  1  high only in IDLE.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM address; K valid on the ROM output one cycle later.
- iv_control  out  1  registered blk_first, held for the whole block.
- control  out  2  phase: 00 = PREF and rounds 0-15; 01 = rounds 16-63; 10 = FIN; 11 = IDLE/DONE.
- opt_en  out  1  ROM K15 optimisation enable (see Optional Feature).
- core_init  out  1  load a..h from IV (iv_control=1) or from the chained H.
- core_en  out  1  execute one round using the current K and W.
- w_load  out  1  round < MSG_WORDS: W comes from the block word.
- w_expand  out  1  round >= MSG_WORDS: W comes from the schedule recurrence.
- round  out  ADDR_W  index of the round executing this cycle.
- digest_add  out  1  H += a..h this cycle.
- digest_valid  out  1  one-cycle pulse: final digest is available.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, any state, including mid-block):
  - State goes to IDLE; the in-flight block is discarded.
  - rom_rd=0, rom_addr=0, iv_control=0, control=11, opt_en=0, core_init=0, core_en=0, w_load=0, w_expand=0, round=0, digest_add=0, digest_valid=0, busy=0, blk_ready=1.
- States: IDLE, PREF, RND, FIN, DONE. All outputs are decoded from registered state, round counter and flags (Moore).
- IDLE:
  - blk_ready=1.
  - Accept on blk_valid & blk_ready: latch first/last flags, go to PREF.
- PREF (1 cycle):
  - rom_rd=1, rom_addr=0, core_init=1, control=00.
  - Next state RND with round=0.
- RND (64 cycles, round 0..63):
  - core_en=1; ROM output holds K[round].
  - Prefetch: rom_rd=1 and rom_addr=round+1 for round<=62; rom_rd=0 and rom_addr=0 at round 63.
  - w_load=1 for rounds 0-15; w_expand=1 for rounds 16-63.
  - control=00 while round<=15, else 01.
  - Round counter increments by 1 with no wrap-around; round 63 goes to FIN.
- FIN (1 cycle):
  - digest_add=1, control=10.
  - If the last flag is set go to DONE, else go to IDLE (the chained H is kept by the core).
- DONE (1 cycle): digest_valid=1, control=11, then IDLE.
- Latency, accept to digest_add: 66 cycles. Accept to digest_valid: 67 cycles.
- Throughput: next accept is possible the cycle after FIN (non-last) or after DONE (last).
- blk_valid outside IDLE is ignored; blk_ready=0 there.
- blk_first and blk_last both set on the same block: single-block message (IV load, then digest_valid).
- iv_control changes only on accept.

Optional Feature:
- Macro SHA256_OPT_K15_EN.
- Defined: opt_en=1 whenever iv_control=1 and rom_addr=15 is issued (round 14, control=00), so the ROM returns the optimised K15 for first blocks. opt_en=0 at all other times.
- Not defined: opt_en is tied to 0 and the ROM always returns the standard K15 (c19bf174).

Decomposition:
- Shared package sha256_pkg holds:
  - state enum;
  - ROUNDS/MSG_WORDS constants;
  - control encodings CTRL_SCHED=00, CTRL_EXP=01, CTRL_FIN=10, CTRL_IDLE=11;
  - constant K15_STD=32'hc19bf174.
- One natural sub-module: sha256_round_cnt, a 6-bit counter with clear, enable and terminal-count flag (tc at 63) reused by the schedule block.

Test Plan:
- Reset then single block (first=1, last=1) -> PREF issues addr 0; rom_addr walks 1..63 during rounds 0..62; core_en high 64 cycles; digest_add 66 cycles after accept; digest_valid at 67; control sequence 00 (17 cycles), 01 (48), 10, 11.
- Two-block message (first=1/last=0, then first=0/last=1) -> iv_control 1 then 0; no digest_valid after block 1; second accept the cycle after FIN; digest_valid only after block 2.
- blk_valid held high during RND -> blk_ready=0, no second accept, round counter unaffected.
- rst asserted at round 30 -> next cycle IDLE, all outputs at reset values; a new block then starts cleanly at addr 0.
- With SHA256_OPT_K15_EN defined and first=1 -> opt_en=1 only in the round-14 cycle (rom_addr=15). With first=0, or without the macro -> opt_en=0 throughout.
- rom_addr/K alignment: for each round r, the ROM output in the RND cycle equals K[r] (e.g. r=0 -> 428a2f98, r=63 -> c67178f2), checked against the reference table.
